// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_ctrl: UART RX frame controller driving a majority-vote sampler.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_in,
  input  logic [4:0]            prescale_in,
  input  logic                  par_en_in,
  input  logic                  par_typ_in,
  input  logic                  sampled_bit_in,
  output logic [4:0]            edge_cnt_out,
  output logic                  data_sample_en_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  par_err_out,
  output logic                  stp_err_out,
  output logic                  busy_out
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_fail_q, par_fail_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  last_edge;

  assign last_edge = (edge_cnt_q == (prescale_in - 5'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= 5'd0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_fail_q <= 1'b0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_fail_q <= par_fail_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = last_edge ? 5'd0 : (edge_cnt_q + 5'd1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_fail_d = par_fail_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = 5'd0;
        // The detection cycle is edge 0 of the start bit.
        if (!rx_in) begin
          state_d    = S_START;
          edge_cnt_d = 5'd1;
          par_fail_d = 1'b0;
        end
      end
      S_START: begin
        if (last_edge) begin
          if (sampled_bit_in) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (last_edge) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = sampled_bit_in;
          bit_cnt_d               = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d = par_en_in ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (last_edge) begin
          par_fail_d = (sampled_bit_in != ((^shift_q) ^ par_typ_in));
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (last_edge) begin
          state_d = S_IDLE;
          if (!par_fail_q && sampled_bit_in) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            par_err_d = par_fail_q;
            stp_err_d = ~sampled_bit_in;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        edge_cnt_d = 5'd0;
      end
    endcase
  end

  assign edge_cnt_out       = edge_cnt_q;
  assign data_sample_en_out = (state_q != S_IDLE);
  assign busy_out           = (state_q != S_IDLE);
  assign data_out           = data_q;
  assign data_valid_out     = valid_q;
  assign par_err_out        = par_err_q;
  assign stp_err_out        = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_ctrl: frame-level bench with a behavioural 3-tap sampler.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_rx_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_in = 1'b1;
  logic [4:0]   prescale_in = 5'd8;
  logic         par_en_in = 1'b0;
  logic         par_typ_in = 1'b0;
  logic         sampled_bit_in;
  logic [4:0]   edge_cnt_out;
  logic         data_sample_en_out;
  logic [W-1:0] data_out;
  logic         data_valid_out;
  logic         par_err_out;
  logic         stp_err_out;
  logic         busy_out;

  uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .rx_in              (rx_in),
    .prescale_in        (prescale_in),
    .par_en_in          (par_en_in),
    .par_typ_in         (par_typ_in),
    .sampled_bit_in     (sampled_bit_in),
    .edge_cnt_out       (edge_cnt_out),
    .data_sample_en_out (data_sample_en_out),
    .data_out           (data_out),
    .data_valid_out     (data_valid_out),
    .par_err_out        (par_err_out),
    .stp_err_out        (stp_err_out),
    .busy_out           (busy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sampler: captures rx at edges p/2-1..p/2+1 and votes.
  logic [2:0] taps;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) taps <= 3'b111;
    else if (data_sample_en_out &&
             int'(edge_cnt_out) >= int'(prescale_in) / 2 - 1 &&
             int'(edge_cnt_out) <= int'(prescale_in) / 2 + 1)
      taps <= {taps[1:0], rx_in};
  end
  assign sampled_bit_in = (taps[0] & taps[1]) | (taps[1] & taps[2]) | (taps[0] & taps[2]);

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int           cyc;
    logic         valid;
    logic         perr;
    logic         serr;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_good = '0;

  exp_t mon_e;
  always @(negedge clk) begin
    if (reset_n && (data_valid_out || par_err_out || stp_err_out)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("data_valid", 32'(data_valid_out), 32'(mon_e.valid));
        check("par_err", 32'(par_err_out), 32'(mon_e.perr));
        check("stp_err", 32'(stp_err_out), 32'(mon_e.serr));
        check("data_out", 32'(data_out), 32'(mon_e.data));
      end
    end
  end

  typedef struct {
    logic [4:0]   p;
    logic [W-1:0] data;
    logic         pen;
    logic         ptyp;
    logic         pflip;
    logic         stop;
    logic         ev;
    logic         ep;
    logic         es;
  } vec_t;

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [4:0] p, input logic [W-1:0] d,
                            input logic pen, input logic ptyp, input logic pflip,
                            input logic stop, input logic ev, input logic ep,
                            input logic es);
    logic [W+2:0] bits;
    int           nb;
    exp_t         e;
    nb   = pen ? W + 3 : W + 2;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = d[i];
    if (pen) bits[W+1] = (^d) ^ ptyp ^ pflip;
    bits[nb-1] = stop;
    prescale_in = p;
    par_en_in   = pen;
    par_typ_in  = ptyp;
    @(negedge clk);
    if (ev) last_good = d;
    e.cyc   = cyc + nb * int'(p);
    e.valid = ev;
    e.perr  = ep;
    e.serr  = es;
    e.data  = last_good;
    sb.push_back(e);
    for (int k = 0; k < nb * int'(p); k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k % int'(p) == 0) begin
          check("busy", 32'(busy_out), 32'(1));
          check("sample_en", 32'(data_sample_en_out), 32'(1));
          check("edge_cnt", 32'(edge_cnt_out), 32'(0));
        end
        if (k % int'(p) != 0 && edge_cnt_out !== 5'(k % int'(p)))
          check("edge_cnt", 32'(edge_cnt_out), 32'(k % int'(p)));
      end
      rx_in = bits[k / int'(p)];
    end
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{5'd8,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{5'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{5'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{5'd8,  8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4] = '{5'd8,  8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{5'd12, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{5'd31, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7] = '{5'd8,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_edge_cnt", 32'(edge_cnt_out), 32'(0));
    check("rst_busy", 32'(busy_out), 32'(0));
    check("rst_sample_en", 32'(data_sample_en_out), 32'(0));
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_pulses", 32'({data_valid_out, par_err_out, stp_err_out}), 32'(0));
    reset_n = 1'b1;
    idle(5);

    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].p, vt[i].data, vt[i].pen, vt[i].ptyp, vt[i].pflip,
                 vt[i].stop, vt[i].ev, vt[i].ep, vt[i].es);
      idle(20);
    end

    // False start: two low cycles then high.
    prescale_in = 5'd8;
    par_en_in   = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) check("abort_busy_start", 32'(busy_out), 32'(1));
      if (k == 7) check("abort_busy_last", 32'(busy_out), 32'(1));
      if (k == 8) begin
        check("abort_busy_fall", 32'(busy_out), 32'(0));
        check("abort_edge_cnt", 32'(edge_cnt_out), 32'(0));
      end
      rx_in = (k < 2) ? 1'b0 : 1'b1;
    end
    idle(10);

    // Back-to-back frames with no idle gap.
    send_frame(5'd16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(5'd16, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);

    // Reset during data bit 4 of a partial 0x33 frame.
    prescale_in = 5'd16;
    for (int k = 0; k < 5 * 16 + 4; k++) begin
      @(negedge clk);
      rx_in = (k < 16) ? 1'b0 : (((8'h33 >> ((k / 16) - 1)) & 8'h01) != 0);
    end
    @(negedge clk);
    check("mid_busy_before_rst", 32'(busy_out), 32'(1));
    reset_n = 1'b0;
    rx_in   = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_out), 32'(0));
    check("mid_rst_sample_en", 32'(data_sample_en_out), 32'(0));
    check("mid_rst_edge_cnt", 32'(edge_cnt_out), 32'(0));
    check("mid_rst_data", 32'(data_out), 32'(0));
    check("mid_rst_pulses", 32'({data_valid_out, par_err_out, stp_err_out}), 32'(0));
    last_good = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    send_frame(5'd16, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that drives the majority-vote data sampler and consumes its voted bit. It detects the start bit and generates the oversample edge count and the sample-enable for the sampler. It deserializes the voted bits LSB-first, checks optional parity and the stop bit, and presents each clean frame with a one-cycle valid pulse. It runs in the UART RX oversampling clock domain, between the RX input synchronizer and the RX-to-system clock-domain-crossing logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB-first.

Ports:
clk  input  1  oversampling clock, one tick per oversample.
reset_n  input  1  asynchronous active-low reset.
rx_in  input  1  synchronized serial line, idle high.
prescale_in  input  5  oversamples per bit; legal range 8..31; must be stable while a frame is in progress.
par_en_in  input  1  1 = frame carries a parity bit.
par_typ_in  input  1  0 = even parity, 1 = odd parity.
sampled_bit_in  input  1  voted bit from the sampler.
edge_cnt_out  output  5  oversample index within the current bit.
data_sample_en_out  output  1  sampler enable.
data_out  output  DATA_WIDTH  last received frame data.
data_valid_out  output  1  one-cycle pulse: data_out holds a clean frame.
par_err_out  output  1  one-cycle pulse at frame end: parity mismatch.
stp_err_out  output  1  one-cycle pulse at frame end: stop bit sampled 0.
busy_out  output  1  a frame is in progress.

Behaviour:
- Reset is asynchronous, active low, clock is clk.
- Reset values:
  - state = IDLE.
  - edge_cnt_out = 0, bit_cnt = 0, shift register = 0.
  - data_out = 0.
  - data_valid_out, par_err_out, stp_err_out, data_sample_en_out, busy_out all 0.
- States: IDLE, START, DATA, PARITY, STOP.
- data_sample_en_out and busy_out are 1 in every state except IDLE; they are decoded from registered state.
- Edge counter:
  - Held at 0 in IDLE.
  - Outside IDLE, increments each clk.
  - Wraps from prescale_in-1 to 0; the wrap marks the bit boundary.
  - The IDLE detection cycle counts as edge 0 of the start bit, so the counter loads 1 on the transition into START.
- sampled_bit_in is consumed only at edge_cnt_out == prescale_in-1. By then the sampler has captured edges p/2-1, p/2 and p/2+1, where p = prescale_in.
- IDLE: if rx_in == 0, go to START. Otherwise stay.
- START, at the last edge:
  - sampled_bit_in == 1: false start (glitch). Go to IDLE with no outputs pulsed.
  - Otherwise go to DATA with bit_cnt = 0.
- DATA, at the last edge:
  - Shift sampled_bit_in into the MSB of the shift register (right shift), so the first bit ends at bit 0.
  - Increment bit_cnt.
  - After DATA_WIDTH bits, go to PARITY if par_en_in is 1, else to STOP.
- PARITY, at the last edge:
  - Expected bit = XOR of the shift register, inverted when par_typ_in = 1.
  - Latch par_fail = (sampled_bit_in != expected).
  - Go to STOP.
  - par_fail is cleared on entry to START.
- STOP, at the last edge:
  - Go to IDLE.
  - On the next cycle, exactly one of these happens:
    - If par_fail is 0 and sampled_bit_in is 1: data_valid_out = 1 for one cycle and data_out = shift register.
    - Otherwise: par_err_out = par_fail and stp_err_out = ~sampled_bit_in, each for one cycle; data_out keeps its previous value.
- Back-to-back frames: IDLE may detect a new start on the cycle right after STOP ends. The pulse outputs and the new detection may coincide.
- par_en_in and par_typ_in are sampled when used. Changing them mid-frame is illegal.
- Reset asserted mid-frame:
  - Immediate return to IDLE.
  - All outputs forced to their reset values.
  - The partial frame is discarded.
- Frame latency, counting the detection cycle as cycle 0:
  - No parity: pulse at cycle (10·p) for DATA_WIDTH = 8.
  - Parity enabled: pulse at cycle (11·p).

Test Plan:
- p=8, no parity, send 0xA5 with a good stop bit -> data_valid_out=1 only at cycle 80 after detection, data_out=0xA5, no error pulse; edge_cnt_out cycles 0..7 and data_sample_en_out=1 throughout the frame.
- p=16, even parity, send 0x3C with parity bit 0 -> valid pulse at cycle 176, data_out=0x3C. Repeat with parity bit 1 -> par_err_out pulse, no valid pulse, data_out still 0x3C.
- p=8, odd parity, 0x01 with parity bit 0 -> clean frame. Then stop bit forced 0 -> stp_err_out pulse, no valid pulse.
- p=8, rx_in low for 2 cycles then high -> START aborts at edge 7, returns to IDLE, no pulses, busy_out falls.
- p=16, two frames 0x55 and 0xAA sent back-to-back with no idle gap -> two valid pulses 160 cycles apart, correct data.
- Assert reset_n low at DATA bit 4, then send 0x0F -> all outputs 0 during reset; next frame received as 0x0F.
